// File: rtl/multi_switch_edge_detect.sv
// multi_switch_edge_detect
//   Multi-channel front-panel switch conditioner. Each channel has a 2-FF
//   synchroniser, a counter debouncer, polarity normalisation, registered
//   press/release pulses and long-press detection with optional auto-repeat.
//
// Ports
//   clk               system clock
//   rst               asynchronous, active-high reset
//   sw                [N_CH] raw asynchronous switch inputs
//   sw_level          [N_CH] debounced logical level (1 = pressed)
//   pos_edge_pulse    [N_CH] one-cycle pulse on press
//   neg_edge_pulse    [N_CH] one-cycle pulse on release
//   either_edge_pulse [N_CH] pos | neg per channel
//   hold_pulse        [N_CH] one-cycle pulse on long-press / auto-repeat
//   any_pulse         OR of pos_edge_pulse | hold_pulse over all channels

module multi_switch_edge_detect_ch #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int ACTIVE_LOW      = 1,
    parameter int HOLD_CYCLES     = 25000000,
    parameter int REPEAT_CYCLES   = 5000000
) (
    input  logic clk,
    input  logic rst,
    input  logic sw,
    output logic level,
    output logic pos,
    output logic neg,
    output logic hold
);
    localparam int  DW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int  HMAX     = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int  HW       = (HMAX > 0) ? $clog2(HMAX + 1) : 1;
    localparam logic INACT   = (ACTIVE_LOW != 0);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
    localparam logic [HW-1:0] REP_LAST  = HW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, WAIT_HOLD, REPEAT} hold_state_t;

    logic          sync1, sync2;
    logic          s;
    logic [DW-1:0] db_cnt;
    logic          deb_done, press_evt, release_evt;

    hold_state_t   state, state_n;
    logic [HW-1:0] hcnt, hcnt_n;
    logic          hold_n;

    // Normalised level: 1 = pressed regardless of board polarity.
    assign s           = sync2 ^ INACT;
    assign deb_done    = (s != level) && (db_cnt == DB_LAST);
    assign press_evt   = deb_done & s;
    assign release_evt = deb_done & ~s;

    // Synchroniser resets to the released raw level so reset release
    // never looks like an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1  <= INACT;
            sync2  <= INACT;
            level  <= 1'b0;
            db_cnt <= '0;
            pos    <= 1'b0;
            neg    <= 1'b0;
        end else begin
            sync1 <= sw;
            sync2 <= sync1;
            pos   <= press_evt;
            neg   <= release_evt;
            if (s == level) begin
                db_cnt <= '0;
            end else if (deb_done) begin
                level  <= s;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            hcnt  <= '0;
            hold  <= 1'b0;
        end else begin
            state <= state_n;
            hcnt  <= hcnt_n;
            hold  <= hold_n;
        end
    end

    // The FSM advances on the same edge that updates level, so hcnt == k
    // in the k-th cycle after pos; a pulse is registered when hcnt reaches
    // the last count, landing exactly HOLD_CYCLES after pos.
    always_comb begin
        state_n = state;
        hcnt_n  = hcnt;
        hold_n  = 1'b0;
        if (HOLD_CYCLES == 0) begin
            state_n = IDLE;
            hcnt_n  = '0;
        end else if (release_evt) begin
            // release wins over a coincident hold expiry
            state_n = IDLE;
            hcnt_n  = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (press_evt) begin
                        state_n = WAIT_HOLD;
                        hcnt_n  = '0;
                    end
                end
                WAIT_HOLD: begin
                    if (hcnt == HOLD_LAST) begin
                        hold_n  = 1'b1;
                        hcnt_n  = '0;
                        state_n = REPEAT;
                    end else begin
                        hcnt_n = hcnt + 1'b1;
                    end
                end
                REPEAT: begin
                    // With no repeat period this state just parks until release.
                    if (REPEAT_CYCLES != 0) begin
                        if (hcnt == REP_LAST) begin
                            hold_n = 1'b1;
                            hcnt_n = '0;
                        end else begin
                            hcnt_n = hcnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state_n = IDLE;
                    hcnt_n  = '0;
                end
            endcase
        end
    end
endmodule

module multi_switch_edge_detect #(
    parameter int N_CH            = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int ACTIVE_LOW      = 1,
    parameter int HOLD_CYCLES     = 25000000,
    parameter int REPEAT_CYCLES   = 5000000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] sw,
    output logic [N_CH-1:0] sw_level,
    output logic [N_CH-1:0] pos_edge_pulse,
    output logic [N_CH-1:0] neg_edge_pulse,
    output logic [N_CH-1:0] either_edge_pulse,
    output logic [N_CH-1:0] hold_pulse,
    output logic            any_pulse
);
    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        multi_switch_edge_detect_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .ACTIVE_LOW     (ACTIVE_LOW),
            .HOLD_CYCLES    (HOLD_CYCLES),
            .REPEAT_CYCLES  (REPEAT_CYCLES)
        ) u_ch (
            .clk  (clk),
            .rst  (rst),
            .sw   (sw[g]),
            .level(sw_level[g]),
            .pos  (pos_edge_pulse[g]),
            .neg  (neg_edge_pulse[g]),
            .hold (hold_pulse[g])
        );
    end

    assign either_edge_pulse = pos_edge_pulse | neg_edge_pulse;
    assign any_pulse         = |(pos_edge_pulse | hold_pulse);
endmodule

// File: tb/tb_multi_switch_edge_detect.sv
module tb_multi_switch_edge_detect;
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] sw_a, lvl_a, pos_a, neg_a, eit_a, hold_a;
    logic [1:0] sw_b, lvl_b, pos_b, neg_b, eit_b, hold_b;
    logic       any_a, any_b;
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    int         c, k;

    typedef struct {
        int         cyc;
        logic [1:0] pos, neg, hold, lvl;
        logic       any;
    } ev_t;
    ev_t qa[$];
    ev_t qb[$];

    multi_switch_edge_detect #(.N_CH(2), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1),
                               .HOLD_CYCLES(10), .REPEAT_CYCLES(5)) dut_a (
        .clk(clk), .rst(rst), .sw(sw_a), .sw_level(lvl_a), .pos_edge_pulse(pos_a),
        .neg_edge_pulse(neg_a), .either_edge_pulse(eit_a), .hold_pulse(hold_a),
        .any_pulse(any_a));

    multi_switch_edge_detect #(.N_CH(2), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(0),
                               .HOLD_CYCLES(0), .REPEAT_CYCLES(5)) dut_b (
        .clk(clk), .rst(rst), .sw(sw_b), .sw_level(lvl_b), .pos_edge_pulse(pos_b),
        .neg_edge_pulse(neg_b), .either_edge_pulse(eit_b), .hold_pulse(hold_b),
        .any_pulse(any_b));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_a(input int t, input logic [1:0] p, input logic [1:0] n,
                          input logic [1:0] h, input logic [1:0] l, input logic an);
        ev_t e;
        e.cyc = t; e.pos = p; e.neg = n; e.hold = h; e.lvl = l; e.any = an;
        qa.push_back(e);
    endtask

    task automatic push_b(input int t, input logic [1:0] p, input logic [1:0] n,
                          input logic [1:0] h, input logic [1:0] l, input logic an);
        ev_t e;
        e.cyc = t; e.pos = p; e.neg = n; e.hold = h; e.lvl = l; e.any = an;
        qb.push_back(e);
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Monitors: any activity on a pulse output must match the next expected event.
    always @(negedge clk) begin : mon_a
        ev_t e;
        if (!rst && ((pos_a | neg_a | hold_a | eit_a) != 2'b00 || any_a)) begin
            if (qa.size() == 0) begin
                total++; bad++;
                $display("FAIL a_unexpected: cyc=%0d pos=%b neg=%b hold=%b any=%b, want no pulse",
                         cyc, pos_a, neg_a, hold_a, any_a);
            end else begin
                e = qa.pop_front();
                chk("a_cyc", cyc, e.cyc);
                chk("a_pos", {30'd0, pos_a}, {30'd0, e.pos});
                chk("a_neg", {30'd0, neg_a}, {30'd0, e.neg});
                chk("a_either", {30'd0, eit_a}, {30'd0, e.pos | e.neg});
                chk("a_hold", {30'd0, hold_a}, {30'd0, e.hold});
                chk("a_level", {30'd0, lvl_a}, {30'd0, e.lvl});
                chk("a_any", {31'd0, any_a}, {31'd0, e.any});
            end
        end
    end

    always @(negedge clk) begin : mon_b
        ev_t e;
        if (!rst && ((pos_b | neg_b | hold_b | eit_b) != 2'b00 || any_b)) begin
            if (qb.size() == 0) begin
                total++; bad++;
                $display("FAIL b_unexpected: cyc=%0d pos=%b neg=%b hold=%b any=%b, want no pulse",
                         cyc, pos_b, neg_b, hold_b, any_b);
            end else begin
                e = qb.pop_front();
                chk("b_cyc", cyc, e.cyc);
                chk("b_pos", {30'd0, pos_b}, {30'd0, e.pos});
                chk("b_neg", {30'd0, neg_b}, {30'd0, e.neg});
                chk("b_either", {30'd0, eit_b}, {30'd0, e.pos | e.neg});
                chk("b_hold", {30'd0, hold_b}, {30'd0, e.hold});
                chk("b_level", {30'd0, lvl_b}, {30'd0, e.lvl});
                chk("b_any", {31'd0, any_b}, {31'd0, e.any});
            end
        end
    end

    initial begin
        rst  = 1'b1;
        sw_a = 2'b11;
        sw_b = 2'b00;
        repeat (3) @(negedge clk);
        chk("rst_lvl_a", {30'd0, lvl_a}, 0);
        chk("rst_pulses_a", {24'd0, pos_a, neg_a, hold_a, eit_a}, 0);
        chk("rst_any_a", {31'd0, any_a}, 0);
        chk("rst_lvl_b", {30'd0, lvl_b}, 0);
        rst = 1'b0;

        // idle: released inputs produce nothing
        repeat (50) @(negedge clk);
        chk("idle_lvl_a", {30'd0, lvl_a}, 0);
        chk("idle_lvl_b", {30'd0, lvl_b}, 0);

        // ch0 press, first hold, release coinciding with first repeat
        c = cyc;
        sw_a[0] = 1'b0;
        push_a(c + 6,  2'b01, 2'b00, 2'b00, 2'b01, 1'b1);
        push_a(c + 16, 2'b00, 2'b00, 2'b01, 2'b01, 1'b1);
        push_a(c + 21, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0);
        wait_until(c + 10);
        chk("s1_level", {30'd0, lvl_a}, 1);
        wait_until(c + 15);
        sw_a[0] = 1'b1;
        wait_until(c + 30);

        // ch0 bounce: never 4 stable samples, so no change
        c = cyc;
        sw_a[0] = 1'b0;
        wait_until(c + 3); sw_a[0] = 1'b1;
        wait_until(c + 4); sw_a[0] = 1'b0;
        wait_until(c + 7); sw_a[0] = 1'b1;
        wait_until(c + 15);
        chk("bounce_level", {30'd0, lvl_a}, 0);
        c = cyc;
        sw_a[0] = 1'b0;
        push_a(c + 6,  2'b01, 2'b00, 2'b00, 2'b01, 1'b1);
        push_a(c + 14, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0);
        wait_until(c + 8); sw_a[0] = 1'b1;
        wait_until(c + 30);

        // ch1 long hold with auto-repeat
        c = cyc;
        sw_a[1] = 1'b0;
        push_a(c + 6,  2'b10, 2'b00, 2'b00, 2'b10, 1'b1);
        push_a(c + 16, 2'b00, 2'b00, 2'b10, 2'b10, 1'b1);
        push_a(c + 21, 2'b00, 2'b00, 2'b10, 2'b10, 1'b1);
        push_a(c + 26, 2'b00, 2'b00, 2'b10, 2'b10, 1'b1);
        push_a(c + 31, 2'b00, 2'b00, 2'b10, 2'b10, 1'b1);
        push_a(c + 36, 2'b00, 2'b10, 2'b00, 2'b00, 1'b0);
        wait_until(c + 30); sw_a[1] = 1'b1;
        wait_until(c + 50);

        // both channels together; release lands on hold expiry cycle
        c = cyc;
        sw_a = 2'b00;
        push_a(c + 6,  2'b11, 2'b00, 2'b00, 2'b11, 1'b1);
        push_a(c + 16, 2'b00, 2'b11, 2'b00, 2'b00, 1'b0);
        wait_until(c + 10); sw_a = 2'b11;
        wait_until(c + 30);

        // reset mid-press: async clear, then re-press after full latency
        c = cyc;
        sw_a[1] = 1'b0;
        push_a(c + 6, 2'b10, 2'b00, 2'b00, 2'b10, 1'b1);
        wait_until(c + 10);
        chk("pre_rst_level", {30'd0, lvl_a}, 2);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_level", {30'd0, lvl_a}, 0);
        chk("async_rst_pulses", {28'd0, pos_a, hold_a}, 0);
        @(negedge clk);
        rst = 1'b0;
        k = cyc;
        push_a(k + 6,  2'b10, 2'b00, 2'b00, 2'b10, 1'b1);
        push_a(k + 14, 2'b00, 2'b10, 2'b00, 2'b00, 1'b0);
        wait_until(k + 8); sw_a[1] = 1'b1;
        wait_until(k + 30);

        // active-high polarity, hold disabled
        c = cyc;
        sw_b[0] = 1'b1;
        push_b(c + 6,   2'b01, 2'b00, 2'b00, 2'b01, 1'b1);
        push_b(c + 106, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0);
        wait_until(c + 50);
        chk("b_held_level", {30'd0, lvl_b}, 1);
        chk("b_held_hold", {30'd0, hold_b}, 0);
        wait_until(c + 100); sw_b[0] = 1'b0;
        wait_until(c + 120);

        chk("a_queue_drained", qa.size(), 0);
        chk("b_queue_drained", qb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
